// File: rtl/stall_mem_responder.sv
// Single-port word memory that answers one request at a time after a pseudo-random
// stall drawn from a free-running 16-bit LFSR; misaligned/out-of-range requests pulse err.
module stall_mem_responder #(
  parameter int unsigned DEPTH_LOG2 = 14,
  parameter int unsigned STALL_EN   = 1,
  parameter int unsigned STALL_BITS = 2,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  localparam int unsigned WORDS = 1 << DEPTH_LOG2;
  localparam int unsigned AW    = DEPTH_LOG2 + 2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state_q, state_d;
  logic [15:0]             lfsr_q, lfsr_d;
  logic [STALL_BITS-1:0]   cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic                    wr_q, wr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             dout_q, dout_d;
  logic                    ready_q, ready_d;
  logic                    busy_q, busy_d;
  logic                    err_q, err_d;
  logic                    addr_bad_c;
  logic [STALL_BITS-1:0]   stall_c;

  logic [31:0] mem [WORDS];

  // Fibonacci x^16+x^14+x^13+x^11+1, shifted left; a nonzero seed never reaches zero
  assign lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign stall_c    = (STALL_EN != 0) ? lfsr_q[STALL_BITS-1:0] : '0;
  assign addr_bad_c = (addr[1:0] != 2'b00) || ((32'(addr) >> AW) != 32'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          if (addr_bad_c) begin
            err_d = 1'b1;
          end else begin
            idx_d   = addr[AW-1:2];
            wr_d    = wr;
            wdata_d = data_in;
            cnt_d   = stall_c;
            state_d = (stall_c == '0) ? RESP : WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - STALL_BITS'(1);
        if (cnt_q <= STALL_BITS'(1)) state_d = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Response data is loaded on the edge that enters RESP so it is valid with ready
    if (state_d == RESP && state_q != RESP) begin
      ready_d = 1'b1;
      dout_d  = wr_d ? wdata_d : mem[idx_d];
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lfsr_q  <= LFSR_SEED;
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      dout_q  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  // Write commits at the end of RESP; a reset that aborts the request leaves state IDLE
  always_ff @(posedge clk) begin
    if (!rst && state_q == RESP && wr_q) mem[idx_q] <= wdata_q;
  end

  assign data_out = dout_q;
  assign ready    = ready_q;
  assign busy     = busy_q;
  assign err      = err_q;

endmodule
